demux_1_to_8: RTL and testbench
===============================

Name: demux_1_to_8

Overview:
- 1-to-8 demultiplexer, the inverse of the board's 8-to-1 selector design.
- A single slide-switch input is routed to one of eight registered LED outputs.
- The output is chosen by three active-low push buttons, synchronised and debounced on-chip.
- Sits directly between board I/O (switch, buttons) and the LED bank. It is the lab's first clocked routing block.

Parameters:
- DEBOUNCE_CYCLES, 500000, clock cycles a button level must stay stable before acceptance (10 ms at 50 MHz); minimum 1.
- SYNC_STAGES, 2, flip-flop stages in each button synchroniser; minimum 2.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- x  input  1  data input from slide switch.
- sel_n  input  3  inverted selector bits from active-low buttons; asynchronous to clock.
- outputs  output  8  registered demultiplexer outputs to LEDs.
- sel_out  output  3  currently accepted (debounced, non-inverted) selector value, for status LEDs.

Behaviour:
- Reset (async, active-high):
  - outputs = 8'h00, sel_out = 3'b000.
  - Synchroniser flops = 1 (buttons released); debounced levels = 1; debounce counters = 0.
  - Takes effect immediately without waiting for a clock edge; all state is held while reset is high.
- Synchronisation: each sel_n bit passes through SYNC_STAGES flops, giving sel_n_sync.
- Debounce, per bit and independent:
  - Each bit keeps a stable level and a counter.
  - sel_n_sync == stable: counter cleared.
  - sel_n_sync != stable: counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and the levels still differ: stable <= sel_n_sync, counter cleared.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps.
- Selector: sel_out = ~stable, registered (it is the stable register inverted). No separate latch.
- Routing, every rising edge:
  - outputs[sel_out] <= x.
  - Unselected outputs hold their value (latched demux) unless CLEAR_UNSELECTED_EN is defined.
- Latency:
  - x change -> selected output: 1 cycle.
  - Button change held stable -> sel_out update: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - sel_out update -> first write to the new output: 1 further cycle.
- Simultaneous events:
  - If sel_out changes on the same edge that samples x, that edge writes to the old sel_out.
  - The new selection receives x from the following edge onward.
- Multiple buttons changing together: each bit debounces separately. Intermediate selector values may appear for the skew between bits, each lasting at least one cycle. This is accepted and not filtered.
- Reset mid-debounce: the counter is discarded. After release, a still-pressed button needs the full SYNC_STAGES + DEBOUNCE_CYCLES again.

Optional Feature:
- Macro: DEMUX_CLEAR_UNSELECTED_EN.
- Defined: pure demux. Each edge, outputs <= 8'h00 with bit sel_out set to x, so exactly one output can be 1.
- Undefined (default): unselected outputs retain their last written value. LEDs act as eight 1-bit memory cells addressed by the buttons.
- Reset behaviour is identical in both builds.

Decomposition:
- Package demux_pkg:
  - SEL_WIDTH = 3, NUM_OUTPUTS = 8.
  - typedef logic[SEL_WIDTH-1:0] sel_t; typedef logic[NUM_OUTPUTS-1:0] demux_out_t.
  - Default DEBOUNCE_CYCLES constant.
- Sub-module button_debounce handles one bit: SYNC_STAGES synchroniser plus counter and stable register. Same clock/reset, ports raw_n in, stable_n out.
- demux_1_to_8 instantiates button_debounce three times (generate loop) and holds the routing register.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2 unless stated):
- Reset: hold reset=1 with x=1, sel_n=3'b000 -> outputs=8'h00 and sel_out=3'b000 throughout, including asynchronously between edges. Release reset with sel_n=3'b111, x=1 -> outputs=8'h01 one edge later.
- Selection: sel_n=3'b101 held, x=1 -> sel_out=3'b010 exactly 6 cycles after the change. Outputs=8'b0000_0101 on the next edge (bit0 from before, bit2 new), default build.
- Bounce rejection: sel_n bit0 low for 3 cycles, then high, repeated 5 times -> sel_out never changes. Low held for 4+ cycles -> accepted.
- Hold vs clear: after scenario 2, set x=0 and select 3'b111 (sel_n=3'b000) -> outputs[7]=0 and outputs[2] stays 1 in the default build. With DEMUX_CLEAR_UNSELECTED_EN, outputs=8'h00.
- Same-edge event: toggle x on the same edge that sel_out changes 3'b000->3'b001 -> outputs[0] takes the new x. outputs[1] takes x from the next edge.
- Mid-debounce reset: pulse reset for 1 cycle after 2 cycles of a stable press -> sel_out=3'b000. Acceptance then requires the full 6 cycles after release.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-8 LED demultiplexer.
package demux_pkg;

  localparam int SEL_WIDTH               = 3;
  localparam int NUM_OUTPUTS             = 8;
  // 10 ms of stability at a 50 MHz board clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  typedef logic [SEL_WIDTH-1:0]   sel_t;
  typedef logic [NUM_OUTPUTS-1:0] demux_out_t;

  // One-hot decode of a selector value into an output mask.
  function automatic demux_out_t sel_onehot(input sel_t sel);
    demux_out_t mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One active-low push button: a SYNC_STAGES flop synchroniser followed by a
// stability counter. The stable level only moves after the synchronised level
// has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
// DEBOUNCE_CYCLES must be >= 1 and SYNC_STAGES must be >= 2.
module button_debounce
  import demux_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic stable_n
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;

  // Shift the asynchronous button level through the synchroniser chain;
  // reset loads "released" (1) so no press is seen out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_n};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Count consecutive disagreeing cycles; accept the new level on the last
  // one. Any agreement clears the count, so short glitches never land.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else if (w_sync == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= w_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign stable_n = r_stable;

endmodule

// File: rtl/demux_1_to_8.sv
// 1-to-8 demultiplexer: the slide switch x is written into the LED output
// addressed by three debounced active-low buttons.
// Build option DEMUX_CLEAR_UNSELECTED_EN: when defined, every unselected
// output is cleared each clock (pure demux); when undefined, unselected
// outputs keep their last written value (eight addressable 1-bit cells).
module demux_1_to_8
  import demux_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   x,
  input  logic [SEL_WIDTH-1:0]   sel_n,
  output logic [NUM_OUTPUTS-1:0] outputs,
  output logic [SEL_WIDTH-1:0]   sel_out
);

  logic [SEL_WIDTH-1:0] w_stable_n;
  demux_out_t           w_mask;
  demux_out_t           w_next;
  demux_out_t           r_outputs;

  // Each selector bit debounces on its own; skew between bits may briefly
  // show intermediate selector values, which is accepted.
  for (genvar i = 0; i < SEL_WIDTH; i++) begin : gen_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn (
      .clock    (clock),
      .reset    (reset),
      .raw_n    (sel_n[i]),
      .stable_n (w_stable_n[i])
    );
  end

  // The accepted selector is the stable registers inverted; no extra latch,
  // so a selector change only affects routing from the following edge.
  assign sel_out = ~w_stable_n;
  assign w_mask  = sel_onehot(sel_out);

  // Next output image: selected bit takes x, others hold or clear.
  always_comb begin
    w_next = '0;
`ifdef DEMUX_CLEAR_UNSELECTED_EN
    w_next = w_mask & {NUM_OUTPUTS{x}};
`else
    w_next = (r_outputs & ~w_mask) | (w_mask & {NUM_OUTPUTS{x}});
`endif
  end

  // Routing register driving the LED bank.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_outputs <= '0;
    end else begin
      r_outputs <= w_next;
    end
  end

  assign outputs = r_outputs;

endmodule

// File: tb/tb_demux_1_to_8.sv
// Directed bench for demux_1_to_8 with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, so a
// held button change shows on sel_out exactly 6 edges after it is applied.
module tb_demux_1_to_8;

  logic       clock;
  logic       reset;
  logic       x;
  logic [2:0] sel_n;
  logic [7:0] outputs;
  logic [2:0] sel_out;

  int n_tests;
  int n_fail;

`ifdef DEMUX_CLEAR_UNSELECTED_EN
  localparam logic [7:0] EXP_SEL_T7  = 8'h04;
  localparam logic [7:0] EXP_HOLD_T6 = 8'h04;
  localparam logic [7:0] EXP_HOLD_T7 = 8'h80;
  localparam logic [7:0] EXP_HOLD_T8 = 8'h00;
  localparam logic [7:0] EXP_SAME_PRE = 8'h00;
  localparam logic [7:0] EXP_SAME_T6 = 8'h01;
  localparam logic [7:0] EXP_SAME_T7 = 8'h02;
  localparam logic [7:0] EXP_RST_T7  = 8'h04;
`else
  localparam logic [7:0] EXP_SEL_T7  = 8'h05;
  localparam logic [7:0] EXP_HOLD_T6 = 8'h05;
  localparam logic [7:0] EXP_HOLD_T7 = 8'h85;
  localparam logic [7:0] EXP_HOLD_T8 = 8'h05;
  localparam logic [7:0] EXP_SAME_PRE = 8'h04;
  localparam logic [7:0] EXP_SAME_T6 = 8'h05;
  localparam logic [7:0] EXP_SAME_T7 = 8'h07;
  localparam logic [7:0] EXP_RST_T7  = 8'h05;
`endif

  demux_1_to_8 #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .x       (x),
    .sel_n   (sel_n),
    .outputs (outputs),
    .sel_out (sel_out)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [7:0] act,
                          input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset held with buttons "pressed" and x=1: everything stays clear.
    reset = 1'b1;
    x     = 1'b1;
    sel_n = 3'b000;
    tick(1);
    check_eq("rst_out", outputs, 8'h00);
    check_eq("rst_sel", {5'b0, sel_out}, 8'h00);
    #3;
    check_eq("rst_out_mid", outputs, 8'h00);
    check_eq("rst_sel_mid", {5'b0, sel_out}, 8'h00);
    tick(3);
    check_eq("rst_out_hold", outputs, 8'h00);
    sel_n = 3'b111;
    tick(1);
    reset = 1'b0;
    tick(1);
    check_eq("rel_out", outputs, 8'h01);
    check_eq("rel_sel", {5'b0, sel_out}, 8'h00);

    // Selection 010 via sel_n=101: sel_out updates on the 6th edge.
    sel_n = 3'b101;
    tick(5);
    check_eq("sel_t5", {5'b0, sel_out}, 8'h00);
    tick(1);
    check_eq("sel_t6", {5'b0, sel_out}, 8'h02);
    check_eq("sel_t6_out", outputs, 8'h01);
    tick(1);
    check_eq("sel_t7_out", outputs, EXP_SEL_T7);

    // Hold vs clear: move to 111, write a 1 then a 0 into bit 7.
    sel_n = 3'b000;
    tick(5);
    check_eq("hold_t5", {5'b0, sel_out}, 8'h02);
    tick(1);
    check_eq("hold_t6", {5'b0, sel_out}, 8'h07);
    check_eq("hold_t6_out", outputs, EXP_HOLD_T6);
    tick(1);
    check_eq("hold_t7_out", outputs, EXP_HOLD_T7);
    x = 1'b0;
    tick(1);
    check_eq("hold_t8_out", outputs, EXP_HOLD_T8);

    // Back to selector 000 with x=0 to prepare the same-edge case.
    sel_n = 3'b111;
    tick(8);
    check_eq("same_pre_sel", {5'b0, sel_out}, 8'h00);
    check_eq("same_pre_out", outputs, EXP_SAME_PRE);

    // Same edge: x rises on the edge where sel_out goes 000 -> 001.
    sel_n = 3'b110;
    tick(5);
    check_eq("same_t5", {5'b0, sel_out}, 8'h00);
    x = 1'b1;
    tick(1);
    check_eq("same_t6_sel", {5'b0, sel_out}, 8'h01);
    check_eq("same_t6_out", outputs, EXP_SAME_T6);
    tick(1);
    check_eq("same_t7_out", outputs, EXP_SAME_T7);

    // Mid-debounce reset: press for 2 cycles, then asynchronous reset.
    sel_n = 3'b101;
    tick(2);
    reset = 1'b1;
    #1;
    check_eq("arst_out", outputs, 8'h00);
    check_eq("arst_sel", {5'b0, sel_out}, 8'h00);
    tick(1);
    reset = 1'b0;
    tick(1);
    check_eq("mrst_t1_out", outputs, 8'h01);
    tick(4);
    check_eq("mrst_t5", {5'b0, sel_out}, 8'h00);
    tick(1);
    check_eq("mrst_t6", {5'b0, sel_out}, 8'h02);
    tick(1);
    check_eq("mrst_t7_out", outputs, EXP_RST_T7);

    // Bounce rejection on bit 0: 3-cycle low pulses never land.
    for (int r = 0; r < 5; r++) begin
      sel_n = 3'b100;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        check_eq("bounce_lo", {5'b0, sel_out}, 8'h02);
      end
      sel_n = 3'b101;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        check_eq("bounce_hi", {5'b0, sel_out}, 8'h02);
      end
    end
    sel_n = 3'b100;
    tick(5);
    check_eq("accept_t5", {5'b0, sel_out}, 8'h02);
    tick(1);
    check_eq("accept_t6", {5'b0, sel_out}, 8'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
